toggle_cover_collector: RTL and testbench

Parametrised toggle-coverage collector. It monitors a WIDTH-bit signal and records each cover point once, in a sticky bitmap. Each newly covered point's global index is streamed out over a valid/ready port, one index per cycle, lowest point first. It sits beside each instrumented signal group and feeds the coverage aggregator instead of calling the simulator per bit per cycle. Unlike the previous per-bit reporter, it supports:

- level or rise/fall toggle mode,
- first-hit deduplication,
- backpressure,
- a running hit count.

---
 rtl/toggle_cover_collector_if.sv | 25 ++
 rtl/toggle_cover_collector.sv | 151 +++++++++++++++
 tb/tb_toggle_cover_collector.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_cover_collector_if.sv
// Newly-covered point stream: one global cover index per transfer,
// handshaked with out_valid/out_ready.
interface toggle_cover_collector_if #(
  parameter int IDX_W = 64
);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;

  // Collector side drives the index stream.
  modport master (
    output out_valid,
    output out_index,
    input  out_ready
  );

  // Aggregator side accepts the index stream.
  modport slave (
    input  out_valid,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: records each cover point of a WIDTH-bit signal
// once (sticky), streams each newly covered point's global index lowest
// first over a valid/ready port, and keeps a running hit count.
module toggle_cover_collector #(
  parameter int WIDTH       = 62,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8940,
  parameter int MODE        = 0,
  parameter int IDX_W       = 64,
  localparam int NPOINTS    = (MODE == 0) ? WIDTH : 2 * WIDTH,
  localparam int CNT_W      = $clog2(NPOINTS + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [WIDTH-1:0]               valid,
  input  logic                           clear,
  toggle_cover_collector_if.master       cov,
  output logic [CNT_W-1:0]               hit_count,
  output logic                           all_covered
);

  localparam int PT_W = (NPOINTS > 1) ? $clog2(NPOINTS) : 1;

  // Output stage states (EMPTY: nothing presented, FULL: index presented).
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("toggle_cover_collector: WIDTH must be in 1..1024");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("toggle_cover_collector: MODE must be 0 or 1");
  end
  if (COVER_INDEX + NPOINTS > COVER_TOTAL) begin : g_bad_range
    $error("toggle_cover_collector: COVER_INDEX + NPOINTS exceeds COVER_TOTAL");
  end

  logic [NPOINTS-1:0] hit;
  logic [NPOINTS-1:0] fresh;
  logic [NPOINTS-1:0] covered;
  logic [NPOINTS-1:0] pending;
  logic [NPOINTS-1:0] pending_nxt;
  logic [CNT_W-1:0]   fresh_cnt;
  logic [PT_W-1:0]    sel;
  logic               sel_any;
  logic               load;
  logic [0:0]         state;
  logic [IDX_W-1:0]   index_q;

  if (MODE == 0) begin : g_level
    // Level mode: point i is hit whenever bit i is sampled high.
    always_comb begin
      hit = enable ? valid : '0;
    end
  end else begin : g_toggle
    logic [WIDTH-1:0] prev;
    logic             prev_ok;

    // Previous-sample history, tracked regardless of enable/clear so that
    // re-enabling never sees a stale edge and the first cycle sees none.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        prev    <= '0;
        prev_ok <= 1'b0;
      end else begin
        prev    <= valid;
        prev_ok <= 1'b1;
      end
    end

    // Toggle mode: even point = rise of bit i, odd point = fall of bit i.
    always_comb begin
      hit = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        hit[2*i]   = enable & prev_ok &  valid[i] & ~prev[i];
        hit[2*i+1] = enable & prev_ok & ~valid[i] &  prev[i];
      end
    end
  end

  // First-hit filter and population count of newly covered points.
  always_comb begin
    fresh     = hit & ~covered;
    fresh_cnt = '0;
    for (int unsigned i = 0; i < NPOINTS; i++) begin
      fresh_cnt = fresh_cnt + CNT_W'(fresh[i]);
    end
  end

  // Lowest-set-bit priority encoder over the registered pending set only.
  always_comb begin
    sel     = '0;
    sel_any = |pending;
    for (int unsigned i = 0; i < NPOINTS; i++) begin
      if (pending[NPOINTS-1-i]) begin
        sel = PT_W'(NPOINTS - 1 - i);
      end
    end
  end

  // Output register may reload when empty or when the current index leaves.
  always_comb begin
    load        = ((state == EMPTY) || cov.out_ready) && sel_any;
    pending_nxt = pending | fresh;
    if (load) begin
      pending_nxt[sel] = 1'b0;
    end
  end

  // Sticky coverage map, pending set and hit count; clear beats any hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      covered   <= '0;
      pending   <= '0;
      hit_count <= '0;
    end else if (clear) begin
      covered   <= '0;
      pending   <= '0;
      hit_count <= '0;
    end else begin
      covered   <= covered | fresh;
      pending   <= pending_nxt;
      hit_count <= hit_count + fresh_cnt;
    end
  end

  // Output stage: present the next pending index, hold it while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      index_q <= '0;
    end else if (clear) begin
      state   <= EMPTY;
    end else if (load) begin
      state   <= FULL;
      index_q <= IDX_W'(COVER_INDEX) + IDX_W'(sel);
    end else if ((state == FULL) && cov.out_ready) begin
      state   <= EMPTY;
    end
  end

  // Output drive and full-coverage flag.
  always_comb begin
    cov.out_valid = (state == FULL);
    cov.out_index = index_q;
    all_covered   = (hit_count == CNT_W'(NPOINTS));
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Self-checking bench for toggle_cover_collector: a level-mode instance
// (WIDTH 62, COVER_INDEX 100) and a toggle-mode instance (WIDTH 4,
// COVER_INDEX 0), with an index scoreboard per instance.
module tb_toggle_cover_collector;

  logic        clock;
  logic        reset;

  logic        en0, clr0;
  logic [61:0] v0;
  logic [5:0]  hc0;
  logic        ac0;

  logic        en1, clr1;
  logic [3:0]  v1;
  logic [3:0]  hc1;
  logic        ac1;

  int          total;
  int          bad;
  int          popped0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  toggle_cover_collector_if #(.IDX_W(64)) c0 ();
  toggle_cover_collector_if #(.IDX_W(64)) c1 ();

  toggle_cover_collector #(
    .WIDTH(62), .COVER_INDEX(100), .COVER_TOTAL(8940), .MODE(0), .IDX_W(64)
  ) dut0 (
    .clock(clock), .reset(reset), .enable(en0), .valid(v0), .clear(clr0),
    .cov(c0), .hit_count(hc0), .all_covered(ac0)
  );

  toggle_cover_collector #(
    .WIDTH(4), .COVER_INDEX(0), .COVER_TOTAL(8940), .MODE(1), .IDX_W(64)
  ) dut1 (
    .clock(clock), .reset(reset), .enable(en1), .valid(v1), .clear(clr1),
    .cov(c1), .hit_count(hc1), .all_covered(ac1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: score any transfer happening at the coming edge, then
  // advance to 1 time unit past the edge.
  task automatic step();
    logic [63:0] e;
    if (c0.out_valid && c0.out_ready) begin
      e = (q0.size() > 0) ? q0.pop_front() : '1;
      chk("d0_stream", c0.out_index, e);
      popped0++;
    end
    if (c1.out_valid && c1.out_ready) begin
      e = (q1.size() > 0) ? q1.pop_front() : '1;
      chk("d1_stream", c1.out_index, e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain0(input int budget);
    for (int n = 0; n < budget && q0.size() > 0; n++) step();
    if (q0.size() != 0) begin
      total++;
      bad++;
      $error("FAIL d0_drain_timeout observed=%0d expected=0", q0.size());
    end
  endtask

  task automatic drain1(input int budget);
    for (int n = 0; n < budget && q1.size() > 0; n++) step();
    if (q1.size() != 0) begin
      total++;
      bad++;
      $error("FAIL d1_drain_timeout observed=%0d expected=0", q1.size());
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    popped0 = 0;
    reset   = 1'b1;
    en0 = 1'b1; clr0 = 1'b0; v0 = '0; c0.out_ready = 1'b1;
    en1 = 1'b1; clr1 = 1'b0; v1 = 4'b0001; c1.out_ready = 1'b1;
    #1;
    chk("rst_d0_valid", 64'(c0.out_valid), 64'd0);
    chk("rst_d0_index", c0.out_index, 64'd0);
    chk("rst_d0_count", 64'(hc0), 64'd0);
    chk("rst_d0_allcov", 64'(ac0), 64'd0);
    chk("rst_d1_valid", 64'(c1.out_valid), 64'd0);
    chk("rst_d1_count", 64'(hc1), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset and idle (d1 bit 0 is high since reset).
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_d0_valid", 64'(c0.out_valid), 64'd0);
      chk("idle_d0_count", 64'(hc0), 64'd0);
      chk("idle_d1_valid", 64'(c1.out_valid), 64'd0);
      chk("idle_d1_count", 64'(hc1), 64'd0);
    end

    // Level burst on bits 0, 5, 61 with backpressure.
    c0.out_ready = 1'b0;
    v0 = '0;
    v0[0] = 1'b1; v0[5] = 1'b1; v0[61] = 1'b1;
    q0.push_back(64'd100); q0.push_back(64'd105); q0.push_back(64'd161);
    step();
    chk("burst_count", 64'(hc0), 64'd3);
    chk("burst_latency_valid", 64'(c0.out_valid), 64'd0);
    v0 = '0;
    step();
    chk("burst_first_valid", 64'(c0.out_valid), 64'd1);
    chk("burst_first_index", c0.out_index, 64'd100);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", 64'(c0.out_valid), 64'd1);
      chk("stall_index", c0.out_index, 64'd100);
    end
    c0.out_ready = 1'b1;
    step();
    chk("burst_second_index", c0.out_index, 64'd105);
    step();
    chk("burst_third_index", c0.out_index, 64'd161);
    step();
    chk("burst_done_valid", 64'(c0.out_valid), 64'd0);

    // Same pattern again: already covered, nothing new.
    v0[0] = 1'b1; v0[5] = 1'b1; v0[61] = 1'b1;
    step();
    v0 = '0;
    for (int k = 0; k < 4; k++) step();
    chk("repeat_count", 64'(hc0), 64'd3);
    chk("repeat_valid", 64'(c0.out_valid), 64'd0);

    // Toggle mode: bit 2 rises then falls.
    v1[2] = 1'b1;
    q1.push_back(64'd4);
    step();
    v1[2] = 1'b0;
    q1.push_back(64'd5);
    step();
    drain1(10);
    chk("toggle_count", 64'(hc1), 64'd2);
    chk("toggle_done_valid", 64'(c1.out_valid), 64'd0);

    // Bit 3 rises while disabled; re-enabling must not see it.
    en1 = 1'b0;
    v1[3] = 1'b1;
    step();
    step();
    en1 = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("reenable_count", 64'(hc1), 64'd2);
    chk("reenable_valid", 64'(c1.out_valid), 64'd0);

    // Full coverage: clear, then every bit high for one cycle.
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    chk("clear_count", 64'(hc0), 64'd0);
    chk("clear_allcov", 64'(ac0), 64'd0);
    v0 = '1;
    for (int k = 0; k < 62; k++) q0.push_back(64'(100 + k));
    step();
    chk("full_count", 64'(hc0), 64'd62);
    chk("full_allcov", 64'(ac0), 64'd1);
    v0 = '0;
    step();
    for (int k = 0; k < 62; k++) begin
      chk("full_consecutive_valid", 64'(c0.out_valid), 64'd1);
      step();
    end
    chk("full_done_valid", 64'(c0.out_valid), 64'd0);
    chk("full_still_allcov", 64'(ac0), 64'd1);

    // Clear during drain, together with a hit on bit 7.
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    v0 = '1;
    for (int k = 0; k < 62; k++) q0.push_back(64'(100 + k));
    step();
    v0 = '0;
    popped0 = 0;
    for (int n = 0; n < 20 && popped0 < 10; n++) step();
    chk("drain_accepted", 64'(popped0), 64'd10);
    chk("drain_presented", c0.out_index, 64'd110);
    clr0 = 1'b1;
    v0[7] = 1'b1;
    step();
    q0.delete();
    clr0 = 1'b0;
    v0 = '0;
    chk("clrdrain_valid", 64'(c0.out_valid), 64'd0);
    chk("clrdrain_count", 64'(hc0), 64'd0);
    for (int k = 0; k < 3; k++) step();
    chk("clrdrain_discard", 64'(hc0), 64'd0);
    v0[7] = 1'b1;
    q0.push_back(64'd107);
    step();
    v0 = '0;
    chk("rehit_count", 64'(hc0), 64'd1);
    drain0(10);

    // Async reset while an index is stalled.
    c0.out_ready = 1'b0;
    v0[3] = 1'b1;
    q0.push_back(64'd103);
    step();
    v0 = '0;
    step();
    chk("prereset_valid", 64'(c0.out_valid), 64'd1);
    chk("prereset_index", c0.out_index, 64'd103);
    #2;
    reset = 1'b1;
    #1;
    q0.delete();
    chk("async_valid", 64'(c0.out_valid), 64'd0);
    chk("async_index", c0.out_index, 64'd0);
    chk("async_count", 64'(hc0), 64'd0);
    chk("async_allcov", 64'(ac0), 64'd0);
    chk("async_d1_count", 64'(hc1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
